wb_arbiter2: RTL and testbench

- Two-master, one-slave Wishbone classic arbiter.
- Lets the pin-driven wishbone bridge (master 0) and an on-chip master such as the USB endpoint DMA (master 1) share the single 14-bit-word-address, 32-bit-data slave bus.
- Grants round-robin, holds the grant for the whole CYC tenure, and routes ACK/read data only to the granted master.

---
 rtl/wb_arbiter2.sv | 168 ++++++++++++++++
 tb/tb_wb_arbiter2.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter2
// Description : Two-master / one-slave Wishbone classic round-robin arbiter.
//               Optional STB watchdog enabled by macro WB_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter2 #(
    parameter int ADR_W          = 14,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    // master 0
    input  logic               m0_CYC,
    input  logic               m0_STB,
    input  logic               m0_WE,
    input  logic [ADR_W-1:0]   m0_ADR,
    input  logic [DAT_W-1:0]   m0_DAT_MOSI,
    input  logic [DAT_W/8-1:0] m0_SEL,
    output logic               m0_ACK,
    output logic               m0_ERR,
    output logic [DAT_W-1:0]   m0_DAT_MISO,
    // master 1
    input  logic               m1_CYC,
    input  logic               m1_STB,
    input  logic               m1_WE,
    input  logic [ADR_W-1:0]   m1_ADR,
    input  logic [DAT_W-1:0]   m1_DAT_MOSI,
    input  logic [DAT_W/8-1:0] m1_SEL,
    output logic               m1_ACK,
    output logic               m1_ERR,
    output logic [DAT_W-1:0]   m1_DAT_MISO,
    // slave
    output logic               s_CYC,
    output logic               s_STB,
    output logic               s_WE,
    output logic [ADR_W-1:0]   s_ADR,
    output logic [DAT_W-1:0]   s_DAT_MOSI,
    output logic [DAT_W/8-1:0] s_SEL,
    input  logic               s_ACK,
    input  logic [DAT_W-1:0]   s_DAT_MISO,
    output logic [1:0]         grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;
    logic   w_last_nxt;
    logic   w_own0;
    logic   w_own1;
    logic   w_stb_own;
    logic   w_stb_block;
    logic   w_tmo_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // r_last holds the most recent owner (1 = m1), so a tie goes to the other.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (m0_CYC && m1_CYC) begin
                    w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
                    w_last_nxt  = ~r_last;
                end else if (m0_CYC) begin
                    w_state_nxt = ST_OWN0;
                    w_last_nxt  = 1'b0;
                end else if (m1_CYC) begin
                    w_state_nxt = ST_OWN1;
                    w_last_nxt  = 1'b1;
                end
            end
            ST_OWN0: if (!m0_CYC) w_state_nxt = ST_IDLE;
            ST_OWN1: if (!m1_CYC) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_own0 = (r_state == ST_OWN0);
    assign w_own1 = (r_state == ST_OWN1);
    assign grant  = {w_own1, w_own0};

    always_comb begin
        s_CYC       = 1'b0;
        w_stb_own   = 1'b0;
        s_WE        = 1'b0;
        s_ADR       = '0;
        s_DAT_MOSI  = '0;
        s_SEL       = '0;
        m0_DAT_MISO = '0;
        m1_DAT_MISO = '0;
        if (w_own0) begin
            s_CYC       = m0_CYC;
            w_stb_own   = m0_STB;
            s_WE        = m0_WE;
            s_ADR       = m0_ADR;
            s_DAT_MOSI  = m0_DAT_MOSI;
            s_SEL       = m0_SEL;
            m0_DAT_MISO = s_DAT_MISO;
        end else if (w_own1) begin
            s_CYC       = m1_CYC;
            w_stb_own   = m1_STB;
            s_WE        = m1_WE;
            s_ADR       = m1_ADR;
            s_DAT_MOSI  = m1_DAT_MOSI;
            s_SEL       = m1_SEL;
            m1_DAT_MISO = s_DAT_MISO;
        end
    end

    assign s_STB  = w_stb_own & ~w_stb_block;
    assign m0_ACK = s_ACK & w_own0 & m0_STB;
    assign m1_ACK = s_ACK & w_own1 & m1_STB;
    assign m0_ERR = w_tmo_hit & w_own0;
    assign m1_ERR = w_tmo_hit & w_own1;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int c_cnt_w = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_tmo_lim = c_cnt_w'(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_tmo_cnt;
    logic               r_tmo_blank;

    // Strobe is withdrawn in the error cycle and the one after it.
    assign w_tmo_hit   = (r_tmo_cnt == c_tmo_lim);
    assign w_stb_block = w_tmo_hit | r_tmo_blank;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo_cnt   <= '0;
            r_tmo_blank <= 1'b0;
        end else begin
            r_tmo_blank <= w_tmo_hit;
            if ((r_state == ST_IDLE) || (w_state_nxt == ST_IDLE) || w_tmo_hit || !s_STB || s_ACK)
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + c_one;
        end
    end
`else
    assign w_tmo_hit   = 1'b0;
    assign w_stb_block = 1'b0;

    // The watchdow limit only shapes logic when the watchdog is built in.
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter2
// Description : Directed + randomized self-checking bench for wb_arbiter2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;

    localparam int ADR_W = 14;
    localparam int DAT_W = 32;
    localparam int SEL_W = DAT_W / 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TMO    = 8;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 255;
    localparam bit TMO_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             m0_CYC, m0_STB, m0_WE, m0_ACK, m0_ERR;
    logic [ADR_W-1:0] m0_ADR;
    logic [DAT_W-1:0] m0_DAT_MOSI, m0_DAT_MISO;
    logic [SEL_W-1:0] m0_SEL;
    logic             m1_CYC, m1_STB, m1_WE, m1_ACK, m1_ERR;
    logic [ADR_W-1:0] m1_ADR;
    logic [DAT_W-1:0] m1_DAT_MOSI, m1_DAT_MISO;
    logic [SEL_W-1:0] m1_SEL;
    logic             s_CYC, s_STB, s_WE, s_ACK;
    logic [ADR_W-1:0] s_ADR;
    logic [DAT_W-1:0] s_DAT_MOSI, s_DAT_MISO;
    logic [SEL_W-1:0] s_SEL;
    logic [1:0]       grant;

    wb_arbiter2 #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_CYC(m0_CYC), .m0_STB(m0_STB), .m0_WE(m0_WE), .m0_ADR(m0_ADR),
        .m0_DAT_MOSI(m0_DAT_MOSI), .m0_SEL(m0_SEL), .m0_ACK(m0_ACK), .m0_ERR(m0_ERR),
        .m0_DAT_MISO(m0_DAT_MISO),
        .m1_CYC(m1_CYC), .m1_STB(m1_STB), .m1_WE(m1_WE), .m1_ADR(m1_ADR),
        .m1_DAT_MOSI(m1_DAT_MOSI), .m1_SEL(m1_SEL), .m1_ACK(m1_ACK), .m1_ERR(m1_ERR),
        .m1_DAT_MISO(m1_DAT_MISO),
        .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE), .s_ADR(s_ADR),
        .s_DAT_MOSI(s_DAT_MOSI), .s_SEL(s_SEL), .s_ACK(s_ACK), .s_DAT_MISO(s_DAT_MISO),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: owner (0 none, 1 m0, 2 m1), last owner, stall count, blank flag.
    int owner = 0;
    bit last  = 1'b1;
    int stall = 0;
    bit blank = 1'b0;

    logic [SEL_W+DAT_W-1:0] wq[$];
    int err_seen;
    int err_at;
    int pulses;
    logic [2:0] stbs;
    logic [DAT_W-1:0] wdat [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit tmo_hit();
        return TMO_EN && (owner != 0) && (stall == TMO);
    endfunction

    function automatic bit exp_stb();
        bit raw;
        raw = (owner == 1) ? m0_STB : (owner == 2) ? m1_STB : 1'b0;
        return raw && !tmo_hit() && !blank;
    endfunction

    // One clock: compare all outputs to the model at negedge, then advance the model.
    task automatic cyc();
        logic [52:0] es;
        logic [33:0] e0, e1;
        int nown;
        bit hit, estb;
        @(negedge clk);
        es = '0;
        e0 = '0;
        e1 = '0;
        hit  = tmo_hit();
        estb = exp_stb();
        if (owner == 1) begin
            es = {m0_CYC, estb, m0_WE, m0_ADR, m0_DAT_MOSI, m0_SEL};
            e0 = {s_ACK && m0_STB, hit, s_DAT_MISO};
        end else if (owner == 2) begin
            es = {m1_CYC, estb, m1_WE, m1_ADR, m1_DAT_MOSI, m1_SEL};
            e1 = {s_ACK && m1_STB, hit, s_DAT_MISO};
        end
        chk("grant", 64'(grant), 64'((owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00));
        chk("slave_bus", 64'({s_CYC, s_STB, s_WE, s_ADR, s_DAT_MOSI, s_SEL}), 64'(es));
        chk("m0_return", 64'({m0_ACK, m0_ERR, m0_DAT_MISO}), 64'(e0));
        chk("m1_return", 64'({m1_ACK, m1_ERR, m1_DAT_MISO}), 64'(e1));
        if (s_CYC && s_STB && s_ACK && s_WE) wq.push_back({s_SEL, s_DAT_MOSI});
        if (m0_ERR) err_seen++;
        @(posedge clk);
        if (!rst_n) begin
            owner = 0;
            last  = 1'b1;
            stall = 0;
            blank = 1'b0;
        end else begin
            nown = owner;
            if (owner == 0) begin
                if (m0_CYC && m1_CYC) nown = last ? 1 : 2;
                else if (m0_CYC)      nown = 1;
                else if (m1_CYC)      nown = 2;
                if (nown != 0) last = (nown == 2);
            end else if (owner == 1 && !m0_CYC) begin
                nown = 0;
            end else if (owner == 2 && !m1_CYC) begin
                nown = 0;
            end
            if (TMO_EN) begin
                if (owner == 0 || nown == 0 || hit || !estb || s_ACK) stall = 0;
                else stall++;
                blank = hit;
            end
            owner = nown;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {m0_CYC, m0_STB, m0_WE, m1_CYC, m1_STB, m1_WE, s_ACK} = '0;
        m0_ADR = '0; m0_DAT_MOSI = '0; m0_SEL = '0;
        m1_ADR = '0; m1_DAT_MOSI = '0; m1_SEL = '0;
        s_DAT_MISO = '0;
        wdat[0] = 32'h11111111; wdat[1] = 32'h22222222; wdat[2] = 32'h33333333;
        err_seen = 0;
        @(posedge clk);
        #1;
        cyc();
        rst_n = 1'b1;
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_slave", 64'({s_CYC, s_STB, s_WE, s_ADR, s_SEL}), 64'(0));
        chk("rst_ackerr", 64'({m0_ACK, m0_ERR, m1_ACK, m1_ERR}), 64'(0));

        // m0 read of word 0x0010, slave answers on the third owned cycle
        m0_CYC = 1; m0_STB = 1; m0_ADR = 14'h0010; m0_SEL = 4'hF;
        cyc();
        chk("rd_grant", 64'(grant), 64'(2'b01));
        chk("rd_adr", 64'(s_ADR), 64'(14'h0010));
        cyc();
        cyc();
        s_ACK = 1; s_DAT_MISO = 32'hCAFEBABE;
        #1;
        chk("rd_ack", 64'(m0_ACK), 64'(1));
        chk("rd_data", 64'(m0_DAT_MISO), 64'(32'hCAFEBABE));
        cyc();
        s_ACK = 0; m0_CYC = 0; m0_STB = 0;
        cyc();
        chk("rd_release", 64'(grant), 64'(0));

        // tie after reset: m0, gap, m1, then m0 again
        rst_n = 0;
        cyc();
        rst_n = 1;
        m0_CYC = 1; m1_CYC = 1;
        cyc();
        chk("tie1", 64'(grant), 64'(2'b01));
        cyc();
        m0_CYC = 0;
        cyc();
        chk("tie_gap", 64'(grant), 64'(2'b00));
        cyc();
        chk("tie2", 64'(grant), 64'(2'b10));
        m1_CYC = 0;
        cyc();
        m0_CYC = 1; m1_CYC = 1;
        cyc();
        chk("tie3", 64'(grant), 64'(2'b01));
        m0_CYC = 0; m1_CYC = 0;
        cyc();
        cyc();

        // m1 locks the bus for three writes while m0 requests
        m1_CYC = 1;
        cyc();
        m0_CYC = 1; m0_STB = 1;
        wq.delete();
        for (int k = 0; k < 3; k++) begin
            m1_STB = 1; m1_WE = 1; m1_SEL = 4'hF; m1_DAT_MOSI = wdat[k]; m1_ADR = ADR_W'(k);
            cyc();
            s_ACK = 1;
            cyc();
            chk("lock_grant", 64'(grant), 64'(2'b10));
            s_ACK = 0; m1_STB = 0;
            cyc();
        end
        chk("lock_count", 64'(wq.size()), 64'(3));
        for (int k = 0; k < 3; k++)
            chk("lock_write", 64'((wq.size() > k) ? wq[k] : '0), 64'({4'hF, wdat[k]}));
        m1_CYC = 0; m1_WE = 0;
        cyc();
        cyc();
        chk("lock_after", 64'(grant), 64'(2'b01));
        m0_CYC = 0; m0_STB = 0;
        cyc();

        // m0 abandons a pending strobe; a late ACK reaches nobody
        m0_CYC = 1; m0_STB = 1;
        cyc();
        cyc();
        m0_CYC = 0;
        cyc();
        s_ACK = 1;
        #1;
        chk("drop_m0ack", 64'(m0_ACK), 64'(0));
        chk("drop_m1ack", 64'(m1_ACK), 64'(0));
        chk("drop_grant", 64'({grant, s_CYC, s_STB}), 64'(0));
        m0_STB = 0;
        cyc();
        s_ACK = 0;

        // reset during an m1 tenure
        m1_CYC = 1; m1_STB = 1;
        cyc();
        cyc();
        rst_n = 0;
        cyc();
        rst_n = 1; s_ACK = 1;
        #1;
        chk("rstmid_bus", 64'({grant, s_CYC, s_STB}), 64'(0));
        chk("rstmid_ack", 64'({m0_ACK, m1_ACK}), 64'(0));
        m1_CYC = 0; m1_STB = 0; s_ACK = 0;
        cyc();

        // hung slave
        err_seen = 0;
        m0_CYC = 1; m0_STB = 1;
        cyc();
`ifdef WB_ARB_TIMEOUT_EN
        err_at = -1; pulses = 0; stbs = '0;
        for (int i = 0; i < 12; i++) begin
            if (m0_ERR) begin
                pulses++;
                if (err_at < 0) err_at = i;
            end
            if (i >= 8 && i <= 10) stbs[i-8] = s_STB;
            cyc();
        end
        chk("tmo_err_at", 64'(err_at), 64'(8));
        chk("tmo_pulses", 64'(pulses), 64'(1));
        chk("tmo_stb", 64'(stbs), 64'(3'b100));
`else
        for (int i = 0; i < 300; i++) cyc();
        chk("no_tmo_err", 64'(err_seen), 64'(0));
`endif
        m0_CYC = 0; m0_STB = 0;
        cyc();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) m0_CYC = ~m0_CYC;
            if ($urandom_range(3) == 0) m1_CYC = ~m1_CYC;
            m0_STB = 1'($urandom); m0_WE = 1'($urandom);
            m1_STB = 1'($urandom); m1_WE = 1'($urandom);
            m0_ADR = ADR_W'($urandom); m0_DAT_MOSI = $urandom; m0_SEL = SEL_W'($urandom);
            m1_ADR = ADR_W'($urandom); m1_DAT_MOSI = $urandom; m1_SEL = SEL_W'($urandom);
            s_ACK = ($urandom_range(2) == 0);
            s_DAT_MISO = $urandom;
            rst_n = ($urandom_range(49) != 0);
            cyc();
        end
        rst_n = 1;
        {m0_CYC, m0_STB, m1_CYC, m1_STB, s_ACK} = '0;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
